// File: rtl/display_pkg.sv
// Shared constants, FSM state encoding and BCD helpers for the
// BCD time keeper. No ports; imported by the RTL and the bench.
package display_pkg;

    localparam int DIGIT_W  = 4;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef struct packed {
        digit_t tens;
        digit_t ones;
    } bcd2_t;

    // Two-digit BCD increment that wraps to 00 after max_val.
    function automatic bcd2_t bcd_inc(bcd2_t v, int max_val);
        bcd2_t r;
        if (v.tens == digit_t'(max_val / 10) &&
            v.ones == digit_t'(max_val % 10)) begin
            r = '0;
        end else if (v.ones == digit_t'(9)) begin
            r.tens = v.tens + digit_t'(1);
            r.ones = '0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + digit_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_time_keeper_if.sv
// Bundle between the time keeper and its surroundings.
// Ports: btn_mode/btn_inc (raw active-low buttons), h10/h1/m10/m1
// (BCD digits), sec_tick, set_hr, set_min. The slave side is the core.
interface bcd_time_keeper_if;
    import display_pkg::*;

    logic   btn_mode;
    logic   btn_inc;
    digit_t h10;
    digit_t h1;
    digit_t m10;
    digit_t m1;
    logic   sec_tick;
    logic   set_hr;
    logic   set_min;

    modport master (
        output btn_mode, btn_inc,
        input  h10, h1, m10, m1, sec_tick, set_hr, set_min
    );

    modport slave (
        input  btn_mode, btn_inc,
        output h10, h1, m10, m1, sec_tick, set_hr, set_min
    );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low pushbutton and emits a
// one-cycle press pulse. Ports: clk, rst_n, btn (raw), press (pulse).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync2;
                // Old level high means released -> pressed.
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_keeper.sv
// HH:MM clock with hidden seconds, set via mode/inc pushbuttons.
// Ports: clk, rst_n (async active-low), bus (slave side of the bundle).
module bcd_time_keeper #(
    parameter int CLK_HZ          = 10_000_000,
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_time_keeper_if.slave bus
);
    import display_pkg::*;

    localparam int PW = $clog2(CLK_HZ + 1);

    state_e        state_q;
    state_e        state_d;
    logic          mode_press;
    logic          inc_press;
    logic          tick;
    logic          go_run;
    logic          hr_inc;
    logic          min_inc;
    logic [PW-1:0] presc;
    logic [5:0]    sec;
    bcd2_t         hours;
    bcd2_t         mins;
    logic          sec_tick_q;
    logic          set_hr_q;
    logic          set_min_q;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_mode (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bus.btn_mode),
        .press(mode_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_inc (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bus.btn_inc),
        .press(inc_press)
    );

    assign tick = (state_q == RUN) && (presc == PW'(CLK_HZ - 1));

    // Mode wins over inc when both land in the same cycle.
    always_comb begin
        state_d = state_q;
        go_run  = 1'b0;
        hr_inc  = 1'b0;
        min_inc = 1'b0;
        case (state_q)
            RUN: begin
                if (mode_press) state_d = SET_HR;
            end
            SET_HR: begin
                if (mode_press) state_d = SET_MIN;
                else if (inc_press) hr_inc = 1'b1;
            end
            SET_MIN: begin
                if (mode_press) begin
                    state_d = RUN;
                    go_run  = 1'b1;
                end else if (inc_press) begin
                    min_inc = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            set_hr_q  <= 1'b0;
            set_min_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_hr_q  <= (state_d == SET_HR);
            set_min_q <= (state_d == SET_MIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            sec        <= '0;
            hours      <= '0;
            mins       <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick;
            if (go_run || state_q != RUN || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
            if (go_run) begin
                sec <= '0;
            end
            if (tick) begin
                if (sec == 6'(MAX_SEC)) begin
                    sec  <= '0;
                    mins <= bcd_inc(mins, MAX_MIN);
                    if (mins == bcd2_t'(8'h59)) begin
                        hours <= bcd_inc(hours, MAX_HOUR);
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end
            if (hr_inc) begin
                hours <= bcd_inc(hours, MAX_HOUR);
            end
            if (min_inc) begin
                mins <= bcd_inc(mins, MAX_MIN);
            end
        end
    end

    assign bus.h10      = hours.tens;
    assign bus.h1       = hours.ones;
    assign bus.m10      = mins.tens;
    assign bus.m1       = mins.ones;
    assign bus.sec_tick = sec_tick_q;
    assign bus.set_hr   = set_hr_q;
    assign bus.set_min  = set_min_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Self-checking bench for bcd_time_keeper with CLK_HZ = 10 and
// DEBOUNCE_CYCLES = 4; tick digits go through a timestamped queue.
module tb_bcd_time_keeper;

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] dig;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    exp_t sb[$];

    bcd_time_keeper_if bus();

    bcd_time_keeper #(
        .CLK_HZ(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] dig_now();
        return {bus.h10, bus.h1, bus.m10, bus.m1};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic press(input bit is_mode);
        if (is_mode) bus.btn_mode = 1'b0;
        else bus.btn_inc = 1'b0;
        cyc(8);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        cyc(8);
    endtask

    task automatic press_both();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        cyc(8);
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        rst_n = 1'b0;
        cyc(3);
        n_run++;
        if (dig_now() !== 16'h0000 || bus.sec_tick !== 1'b0 ||
            bus.set_hr !== 1'b0 || bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got dig=%h tick=%b hr=%b min=%b, required 0000 0 0 0",
                     dig_now(), bus.sec_tick, bus.set_hr, bus.set_min);
        end
        rst_n = 1'b1;
        cyc(20);
        n_run++;
        if (bus.set_hr !== 1'b0 || bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got hr=%b min=%b, required 0 0",
                     bus.set_hr, bus.set_min);
        end
    endtask

    task automatic test_run();
        int   presc;
        int   secs;
        int   mins;
        int   ticks;
        exp_t e;
        presc = 0;
        secs  = 0;
        mins  = 0;
        ticks = 0;
        sb.delete();
        do_reset();
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (presc == 9) begin
                presc = 0;
                secs++;
                if (secs == 60) begin
                    secs = 0;
                    mins++;
                end
                e.cyc = 32'(c);
                e.dig = {8'h00, 4'(mins / 10), 4'(mins % 10)};
                sb.push_back(e);
            end else begin
                presc++;
            end
            if (bus.sec_tick === 1'b1) begin
                ticks++;
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL tick_spurious: got tick at cycle %0d, required none", c);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc !== 32'(c) || e.dig !== dig_now()) begin
                        n_fail++;
                        $display("FAIL tick_run: got cyc %0d dig %h, required cyc %0d dig %h",
                                 c, dig_now(), e.cyc, e.dig);
                    end
                end
            end
        end
        n_run++;
        if (sb.size() != 0 || ticks != 60) begin
            n_fail++;
            $display("FAIL tick_count: got %0d ticks, required 60", ticks);
        end
        sb.delete();
        n_run++;
        if (dig_now() !== 16'h0001) begin
            n_fail++;
            $display("FAIL run_600: got %h, required 0001", dig_now());
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (dig_now() !== 16'h0000 || bus.sec_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got dig=%h tick=%b, required 0000 0",
                     dig_now(), bus.sec_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_glitch();
        do_reset();
        bus.btn_inc = 1'b0;
        cyc(3);
        bus.btn_inc  = 1'b1;
        bus.btn_mode = 1'b0;
        cyc(3);
        bus.btn_mode = 1'b1;
        cyc(10);
        n_run++;
        if (bus.set_hr !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_glitch: got set_hr=%b, required 0", bus.set_hr);
        end
        bus.btn_inc = 1'b0;
        cyc(10);
        bus.btn_inc = 1'b1;
        cyc(10);
        n_run++;
        if (dig_now() !== 16'h0000 || bus.set_hr !== 1'b0) begin
            n_fail++;
            $display("FAIL inc_in_run: got dig=%h hr=%b, required 0000 0",
                     dig_now(), bus.set_hr);
        end
    endtask

    task automatic test_set();
        do_reset();
        press(1'b1);
        n_run++;
        if (bus.set_hr !== 1'b1 || bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_set_hr: got hr=%b min=%b, required 1 0",
                     bus.set_hr, bus.set_min);
        end
        repeat (24) press(1'b0);
        n_run++;
        if (dig_now() !== 16'h0000) begin
            n_fail++;
            $display("FAIL hr_wrap: got %h, required 0000", dig_now());
        end
        press(1'b0);
        n_run++;
        if (dig_now() !== 16'h0100) begin
            n_fail++;
            $display("FAIL hr_25: got %h, required 0100", dig_now());
        end
        press(1'b1);
        n_run++;
        if (bus.set_min !== 1'b1 || bus.set_hr !== 1'b0) begin
            n_fail++;
            $display("FAIL enter_set_min: got hr=%b min=%b, required 0 1",
                     bus.set_hr, bus.set_min);
        end
        repeat (60) press(1'b0);
        n_run++;
        if (dig_now() !== 16'h0100) begin
            n_fail++;
            $display("FAIL min_wrap: got %h, required 0100", dig_now());
        end
        press(1'b0);
        n_run++;
        if (dig_now() !== 16'h0101) begin
            n_fail++;
            $display("FAIL min_61: got %h, required 0101", dig_now());
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        press(1'b1);
        press_both();
        n_run++;
        if (bus.set_min !== 1'b1 || bus.set_hr !== 1'b0 ||
            dig_now() !== 16'h0000) begin
            n_fail++;
            $display("FAIL mode_and_inc: got hr=%b min=%b dig=%h, required 0 1 0000",
                     bus.set_hr, bus.set_min, dig_now());
        end
    endtask

    task automatic test_exit_tick();
        int w;
        w = 0;
        bus.btn_mode = 1'b0;
        while (bus.set_min === 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_run++;
        if (bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_set_min: got set_min=%b, required 0", bus.set_min);
        end
        w = 0;
        while (bus.sec_tick !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        n_run++;
        if (w != 10 || bus.sec_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL first_tick: got %0d cycles, required 10", w);
        end
        cyc(10);
        bus.btn_mode = 1'b1;
        cyc(8);
        n_run++;
        if (bus.set_hr !== 1'b0 || bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_no_repeat: got hr=%b min=%b, required 0 0",
                     bus.set_hr, bus.set_min);
        end
    endtask

    task automatic test_rollover();
        int   w;
        exp_t e;
        do_reset();
        press(1'b1);
        repeat (23) press(1'b0);
        press(1'b1);
        repeat (59) press(1'b0);
        n_run++;
        if (dig_now() !== 16'h2359) begin
            n_fail++;
            $display("FAIL set_2359: got %h, required 2359", dig_now());
        end
        sb.delete();
        w = 0;
        bus.btn_mode = 1'b0;
        while (bus.set_min === 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int i = 1; i <= 60; i++) begin
            e.cyc = 32'(10 * i);
            e.dig = (i == 60) ? 16'h0000 : 16'h2359;
            sb.push_back(e);
        end
        w = 0;
        while (sb.size() != 0 && w < 700) begin
            @(negedge clk);
            w++;
            if (w == 20) bus.btn_mode = 1'b1;
            if (bus.sec_tick === 1'b1) begin
                e = sb.pop_front();
                n_run++;
                if (e.cyc !== 32'(w) || e.dig !== dig_now()) begin
                    n_fail++;
                    $display("FAIL rollover_tick: got cyc %0d dig %h, required cyc %0d dig %h",
                             w, dig_now(), e.cyc, e.dig);
                end
            end
        end
        bus.btn_mode = 1'b1;
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rollover_timeout: got %0d pending, required 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_set();
        do_reset();
        press(1'b1);
        repeat (5) press(1'b0);
        n_run++;
        if (dig_now() !== 16'h0500) begin
            n_fail++;
            $display("FAIL hr_5: got %h, required 0500", dig_now());
        end
        bus.btn_inc = 1'b0;
        cyc(4);
        #2;
        rst_n = 1'b0;
        #1;
        n_run++;
        if (dig_now() !== 16'h0000 || bus.set_hr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_set: got dig=%h hr=%b, required 0000 0",
                     dig_now(), bus.set_hr);
        end
        bus.btn_inc = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(20);
        n_run++;
        if (dig_now() !== 16'h0000 || bus.set_hr !== 1'b0 ||
            bus.set_min !== 1'b0) begin
            n_fail++;
            $display("FAIL after_mid_reset: got dig=%h hr=%b min=%b, required 0000 0 0",
                     dig_now(), bus.set_hr, bus.set_min);
        end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        test_reset();
        test_run();
        test_async_reset();
        test_glitch();
        test_set();
        test_same_cycle();
        test_exit_tick();
        test_rollover();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_time_keeper.md
BCD_TIME_KEEPER -- requirements
Module: bcd_time_keeper

Interface
REQ-001 Parameter CLK_HZ, default 10_000_000: Clock cycles per one-second tick.
REQ-002 Parameter DEBOUNCE_CYCLES, default 100_000: cycles a button level must hold before it is accepted (10 ms at 10 MHz).
REQ-003 Clock  in  1  single system clock; all state is updated on its rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 btn_mode  in  1  raw pushbutton, active-low (pressed = 0), asynchronous to Clock.
REQ-006 btn_inc  in  1  raw pushbutton, active-low, asynchronous to Clock.
REQ-007 h10, h1, m10, m1  out  4 each  BCD hour-tens, hour-ones, minute-tens, minute-ones, registered.
REQ-008 sec_tick  out  1  one-cycle pulse, coincident with each accepted one-second tick in RUN.
REQ-009 set_hr, set_min  out  1 each  high while the FSM is in SET_HR or SET_MIN respectively, registered.

Function
REQ-010 Prescaler counts 0..CLK_HZ-1 and wraps; tick = (count == CLK_HZ-1); it counts only in RUN and holds 0 otherwise.
REQ-011 Internal seconds counter is 0..59, binary or BCD, and is not an output.
REQ-012 In RUN on tick: sec+1; at 59, sec->0 and minute+1.
REQ-013 Minute carry: m1 9->0 with m10+1; at m10:m1 = 5:9, the field goes to 0:0 with hour+1.
REQ-014 Hour carry: h1 9->0 with h10+1; at 23, the field goes to 00; 23:59:59 + tick -> 00:00:00.
REQ-015 Counter updates land on the same edge as the internal tick; new digits and sec_tick are visible in the cycle after prescaler == CLK_HZ-1.
REQ-016 Each button: 2-FF synchronizer, then debounce counter; the debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-017 Press event is a one-cycle pulse on the debounced released->pressed transition; holding the button produces no repeat.
REQ-018 FSM states: RUN, SET_HR, SET_MIN. Mode press: RUN->SET_HR->SET_MIN->RUN.
REQ-019 SET_HR, inc press: hour+1 with 23->00 wrap; minutes are unaffected.
REQ-020 SET_MIN, inc press: minute+1 with 59->00 wrap; there is no carry into hours.
REQ-021 Inc press in RUN is ignored.
REQ-022 Mode and inc press events in the same cycle: the mode transition is taken and inc is discarded.
REQ-023 On SET_MIN->RUN: seconds -> 0 and prescaler -> 0, so the first tick follows CLK_HZ cycles later.
REQ-024 Digits never leave their legal ranges: h10 0..2, h1 0..9 (0..3 when h10 = 2), m10 0..5, m1 0..9.

Reset
REQ-025 While Reset = 0, asynchronously: digits 0, seconds 0, prescaler 0, state RUN, sec_tick 0, set_hr/set_min 0.
REQ-026 Reset also sets synchronizers and debounced levels to released (1), so that releasing reset generates no press event.
REQ-027 Reset asserted mid-set or mid-debounce abandons the operation entirely; no partial increment is retained.

Structure
REQ-028 Shared package display_pkg: FSM state encoding localparams (RUN = 0, SET_HR = 1, SET_MIN = 2), BCD digit width 4, max-value constants (23, 59).
REQ-029 Sub-module button_debounce (sync + debounce + press pulse) is parameterised by DEBOUNCE_CYCLES and instantiated twice.
REQ-030 Digit outputs connect directly to the existing multiplexed display driver's h10/h1/m10/m1 inputs.

Verification (CLK_HZ = 10, DEBOUNCE_CYCLES = 4)
REQ-031 Reset, then run 600 cycles -> sec_tick every 10 cycles; after 60 ticks m1 = 1, other digits 0.
REQ-032 Force 23:59:59, one tick -> h10 h1 m10 m1 = 0 0 0 0 the next cycle.
REQ-033 btn_inc low for 3 cycles in RUN -> no press event; low for 10 cycles in RUN -> digits unchanged.
REQ-034 Mode press, 25 inc presses -> set_hr = 1, hours = 01; mode press, 61 inc presses -> minutes = 01, hours remain 01.
REQ-035 Mode and inc presses aligned in the same cycle while in SET_HR -> state SET_MIN, hours unchanged.
REQ-036 In SET_MIN, mode press -> RUN; first sec_tick exactly 10 cycles after the transition; Reset pulse mid-SET_HR -> RUN, 00:00.
